if_id_frontend: RTL and testbench

Parametrised fetch/decode front-end for the 5-stage RISC-V pipeline. Owns the PC register and the IF/ID pipeline register. Resolves every front-end hazard in one place: trap and branch redirects with a configurable flush depth, precise register-based load-use interlock, instruction-cache miss bubbles, and whole-pipe data-cache freezes. Exposes saturating stall and flush performance counters. Sits between the instruction cache and the decode/control stage.

---
 rtl/if_id_frontend.sv | 144 ++++++++++++++
 tb/tb_if_id_frontend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_frontend.sv
// Fetch/decode front-end: owns the PC and the IF/ID register and resolves redirect,
// load-use, cache-stall and freeze hazards, with saturating stall/flush counters.
module if_id_frontend #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              FLUSH_SLOTS = 1,
   parameter logic [31:0]     NOP         = 32'h00000013,
   parameter int              CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic [XLEN-1:0]   pc_out,
   input  logic [31:0]       inst_in,
   input  logic              imem_stall,
   input  logic              dmem_stall,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   input  logic              trap_valid,
   input  logic [XLEN-1:0]   trap_pc,
   input  logic              idex_mem_read,
   input  logic [4:0]        idex_rd,
   output logic [31:0]       ifid_inst,
   output logic [XLEN-1:0]   ifid_pc,
   output logic              ifid_valid,
   output logic              id_bubble,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_cycles
);

   // state    | meaning
   // ST_RUN   | normal fetch; load-use and imem stalls are honoured
   // ST_FLUSH | wrong-path slots after a redirect; IF/ID forced to NOP
   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   localparam int REM_W = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;

   state_t            state_q, state_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [31:0]       ifid_inst_q, ifid_inst_d;
   logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic [6:0]        opcode;
   logic [4:0]        rs1, rs2;
   logic              rs1_used, rs2_used, load_use;
   logic              stall_inc, flush_inc;
   logic [XLEN-1:0]   target;

   // Hazard detect never looks at redirect/trap so id_bubble stays off those paths.
   always_comb begin
      opcode   = ifid_inst_q[6:0];
      rs1      = ifid_inst_q[19:15];
      rs2      = ifid_inst_q[24:20];
      rs1_used = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
      rs2_used = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);
      load_use = (state_q == ST_RUN) && ifid_valid_q && idex_mem_read && (idex_rd != 5'd0) &&
                 ((rs1_used && (rs1 == idex_rd)) || (rs2_used && (rs2 == idex_rd)));
      id_bubble = load_use && !dmem_stall;
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      pc_d         = pc_q;
      ifid_inst_d  = ifid_inst_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      target       = trap_valid ? trap_pc : redirect_pc;

      if (dmem_stall) begin
         stall_inc = 1'b1;
      end else if (trap_valid || redirect_valid) begin
         pc_d         = {target[XLEN-1:2], 2'b00};
         ifid_inst_d  = NOP;
         ifid_valid_d = 1'b0;
         flush_inc    = 1'b1;
         if (FLUSH_SLOTS > 1) begin
            state_d = ST_FLUSH;
            rem_d   = REM_W'(FLUSH_SLOTS - 1);
         end else begin
            state_d = ST_RUN;
            rem_d   = '0;
         end
      end else if (state_q == ST_FLUSH) begin
         ifid_inst_d  = NOP;
         ifid_valid_d = 1'b0;
         flush_inc    = 1'b1;
         rem_d        = rem_q - 1'b1;
         if (rem_q <= REM_W'(1)) begin
            state_d = ST_RUN;
            rem_d   = '0;
         end
      end else if (load_use) begin
         stall_inc = 1'b1;
      end else if (imem_stall) begin
         ifid_inst_d  = NOP;
         ifid_valid_d = 1'b0;
         stall_inc    = 1'b1;
      end else begin
         ifid_inst_d  = inst_in;
         ifid_pc_d    = pc_q;
         ifid_valid_d = 1'b1;
         pc_d         = pc_q + XLEN'(4);
      end

      stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         rem_q        <= '0;
         pc_q         <= RESET_PC;
         ifid_inst_q  <= NOP;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         pc_q         <= pc_d;
         ifid_inst_q  <= ifid_inst_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_valid_q <= ifid_valid_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign pc_out       = pc_q;
   assign ifid_inst    = ifid_inst_q;
   assign ifid_pc      = ifid_pc_q;
   assign ifid_valid   = ifid_valid_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_if_id_frontend.sv
// Directed bench for if_id_frontend with FLUSH_SLOTS=2 and 4-bit counters;
// instruction memory returns the fetch address as the instruction word.
module tb_if_id_frontend;

   localparam logic [31:0] NOP_I = 32'h00000013;
   localparam logic [31:0] ADD_I = 32'h007302B3; // add x5,x6,x7
   localparam logic [31:0] LUI_I = 32'h000383B7; // lui x7 with rs1 field = 7

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_out, inst_in, ifid_inst, ifid_pc;
   logic        imem_stall = 0, dmem_stall = 0, redirect_valid = 0, trap_valid = 0;
   logic [31:0] redirect_pc = '0, trap_pc = '0;
   logic        idex_mem_read = 0;
   logic [4:0]  idex_rd = '0;
   logic        ifid_valid, id_bubble;
   logic [3:0]  stall_cycles, flush_cycles;
   logic        inst_ovr_en = 0;
   logic [31:0] inst_ovr = '0;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   always_comb inst_in = inst_ovr_en ? inst_ovr : pc_out;

   if_id_frontend #(
      .XLEN(32), .RESET_PC(32'h0), .FLUSH_SLOTS(2), .NOP(NOP_I), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .pc_out(pc_out), .inst_in(inst_in),
      .imem_stall(imem_stall), .dmem_stall(dmem_stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .trap_valid(trap_valid), .trap_pc(trap_pc),
      .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
      .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .id_bubble(id_bubble), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      // reset held three cycles
      repeat (3) step();
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_inst", ifid_inst, NOP_I);
      chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rst_bubble", {31'b0, id_bubble}, 32'd0);
      chk("rst_stall", {28'b0, stall_cycles}, 32'd0);
      chk("rst_flush", {28'b0, flush_cycles}, 32'd0);
      rst = 1'b1;

      // straight-line stream
      for (int i = 0; i < 8; i++) begin
         step();
         chk("stream_ifid_pc", ifid_pc, 32'(4 * i));
         chk("stream_inst", ifid_inst, 32'(4 * i));
         chk("stream_valid", {31'b0, ifid_valid}, 32'd1);
         chk("stream_pc", pc_out, 32'(4 * (i + 1)));
      end
      chk("stream_stall", {28'b0, stall_cycles}, 32'd0);
      chk("stream_flush", {28'b0, flush_cycles}, 32'd0);

      // redirect to 0x100 from pc 0x20: two NOP slots then target
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_valid = 1'b0;
      chk("redir_pc", pc_out, 32'h100);
      chk("redir_nop0", ifid_inst, NOP_I);
      chk("redir_valid0", {31'b0, ifid_valid}, 32'd0);
      step();
      chk("redir_hold_pc", pc_out, 32'h100);
      chk("redir_valid1", {31'b0, ifid_valid}, 32'd0);
      step();
      chk("redir_tgt_pc", ifid_pc, 32'h100);
      chk("redir_tgt_valid", {31'b0, ifid_valid}, 32'd1);
      chk("redir_flush", {28'b0, flush_cycles}, 32'd2);

      // misaligned target is word-aligned
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      redirect_valid = 1'b0;
      chk("align_pc", pc_out, 32'h100);
      step();
      step();
      chk("align_ifid_pc", ifid_pc, 32'h100);
      chk("align_flush", {28'b0, flush_cycles}, 32'd4);

      // load-use on rs2 of add x5,x6,x7
      do_reset();
      inst_ovr_en = 1'b1; inst_ovr = ADD_I;
      step();
      inst_ovr_en = 1'b0;
      chk("lu_setup", ifid_inst, ADD_I);
      idex_mem_read = 1'b1; idex_rd = 5'd7;
      #1;
      chk("lu_bubble", {31'b0, id_bubble}, 32'd1);
      step();
      chk("lu_hold_inst", ifid_inst, ADD_I);
      chk("lu_hold_pc", pc_out, 32'h4);
      chk("lu_stall", {28'b0, stall_cycles}, 32'd1);
      idex_rd = 5'd0;
      #1;
      chk("lu_rd0_bubble", {31'b0, id_bubble}, 32'd0);
      step();
      chk("lu_resume_pc", ifid_pc, 32'h4);
      chk("lu_resume_pc_out", pc_out, 32'h8);

      // lui does not read rs1
      idex_mem_read = 1'b0;
      inst_ovr_en = 1'b1; inst_ovr = LUI_I;
      step();
      inst_ovr_en = 1'b0;
      idex_mem_read = 1'b1; idex_rd = 5'd7;
      #1;
      chk("lui_bubble", {31'b0, id_bubble}, 32'd0);
      step();
      chk("lui_ifid_pc", ifid_pc, 32'hC);
      chk("lui_stall", {28'b0, stall_cycles}, 32'd1);
      idex_mem_read = 1'b0; idex_rd = 5'd0;

      // imem stall for three cycles
      do_reset();
      step();
      imem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("imem_pc", pc_out, 32'h4);
         chk("imem_valid", {31'b0, ifid_valid}, 32'd0);
         chk("imem_nop", ifid_inst, NOP_I);
      end
      chk("imem_stall_cnt", {28'b0, stall_cycles}, 32'd3);
      imem_stall = 1'b0;
      step();
      chk("imem_resume", ifid_pc, 32'h4);

      // dmem freeze with a pending redirect
      dmem_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("dmem_pc", pc_out, 32'h8);
         chk("dmem_ifid_pc", ifid_pc, 32'h4);
         chk("dmem_valid", {31'b0, ifid_valid}, 32'd1);
      end
      chk("dmem_stall_cnt", {28'b0, stall_cycles}, 32'd5);
      chk("dmem_flush_cnt", {28'b0, flush_cycles}, 32'd0);
      dmem_stall = 1'b0;
      step();
      redirect_valid = 1'b0;
      chk("dmem_redir_pc", pc_out, 32'h200);
      step();
      step();
      chk("dmem_redir_tgt", ifid_pc, 32'h200);

      // trap beats redirect; redirect inside FLUSH restarts the count
      trap_valid = 1'b1; trap_pc = 32'h80; redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      trap_valid = 1'b0;
      chk("prio_pc", pc_out, 32'h80);
      redirect_pc = 32'h300;
      step();
      redirect_valid = 1'b0;
      chk("restart_pc", pc_out, 32'h300);
      step();
      chk("restart_slot_valid", {31'b0, ifid_valid}, 32'd0);
      step();
      chk("restart_tgt", ifid_pc, 32'h300);
      chk("restart_tgt_valid", {31'b0, ifid_valid}, 32'd1);
      chk("restart_flush", {28'b0, flush_cycles}, 32'd5);

      // reset asserted mid-FLUSH
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("mid_rst_pc", pc_out, 32'h0);
      chk("mid_rst_valid", {31'b0, ifid_valid}, 32'd0);
      chk("mid_rst_flush", {28'b0, flush_cycles}, 32'd0);
      chk("mid_rst_stall", {28'b0, stall_cycles}, 32'd0);
      step();
      rst = 1'b1;
      step();
      chk("post_rst_valid", {31'b0, ifid_valid}, 32'd1);
      chk("post_rst_pc", pc_out, 32'h4);

      // stall counter saturation
      imem_stall = 1'b1;
      repeat (20) step();
      imem_stall = 1'b0;
      chk("sat_stall", {28'b0, stall_cycles}, 32'd15);

      // PC wrap
      redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
      step();
      redirect_valid = 1'b0;
      chk("wrap_tgt", pc_out, 32'hFFFFFFFC);
      step();
      step();
      chk("wrap_pc", pc_out, 32'h0);
      chk("wrap_ifid_pc", ifid_pc, 32'hFFFFFFFC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
